// File: rtl/adaptive_phase_scheduler_pkg.sv
// Shared types and width helpers for the adaptive traffic-phase scheduler.
package traffic_pkg;

    typedef enum logic [1:0] {
        PH_ALLRED = 2'd0,
        PH_GREEN  = 2'd1,
        PH_YELLOW = 2'd2
    } phase_e;

    // Width of a per-direction lane sum; one spare bit so the sum never wraps.
    function automatic int sum_w(input int cnt_w, input int lanes);
        return cnt_w + $clog2(lanes) + 1;
    endfunction

    // Width of a direction index (at least one bit).
    function automatic int dir_w(input int n_dir);
        return (n_dir > 1) ? $clog2(n_dir) : 1;
    endfunction

endpackage

// File: rtl/adaptive_phase_scheduler_if.sv
// Sensor-count / light-driver bundle of the adaptive phase scheduler.
interface adaptive_phase_scheduler_if #(
    parameter int N_DIR = 4,
    parameter int LANES = 2,
    parameter int CNT_W = 8
);
    import traffic_pkg::*;

    localparam int DIR_W = dir_w(N_DIR);

    logic                         enable;
    logic [N_DIR*LANES*CNT_W-1:0] lane_count;
    logic [N_DIR*LANES-1:0]       green;
    logic [N_DIR*LANES-1:0]       yellow;
    logic [DIR_W-1:0]             cur_dir;
    phase_e                       phase;

    modport master (
        output enable, lane_count,
        input  green, yellow, cur_dir, phase
    );

    modport slave (
        input  enable, lane_count,
        output green, yellow, cur_dir, phase
    );

endinterface

// File: rtl/adaptive_phase_scheduler_dir_arbiter.sv
// Combinational next-direction selector: starving dirs first (lowest index),
// then the largest sum (lowest index on ties), else explicit round-robin step.
module dir_arbiter #(
    parameter int N_DIR = 4,
    parameter int SUM_W = 10,
    parameter int DIR_W = 2
) (
    input  logic [N_DIR*SUM_W-1:0] sums,
    input  logic [N_DIR-1:0]       starve,
    input  logic [DIR_W-1:0]       cur_dir,
    output logic [DIR_W-1:0]       next_dir,
    output logic                   challenger_gt_own
);

    logic [SUM_W-1:0] own_sum;
    logic [SUM_W-1:0] best_sum;
    logic [SUM_W-1:0] cand;
    logic [DIR_W-1:0] starve_dir;
    logic [DIR_W-1:0] best_dir;
    logic             found_starve;
    logic             found_best;

    // Scan all other directions for starvation, the maximum sum and any challenger.
    always_comb begin
        own_sum           = sums[int'(cur_dir)*SUM_W +: SUM_W];
        best_sum          = '0;
        cand              = '0;
        starve_dir        = '0;
        best_dir          = '0;
        found_starve      = 1'b0;
        found_best        = 1'b0;
        challenger_gt_own = 1'b0;
        for (int d = 0; d < N_DIR; d++) begin
            cand = sums[d*SUM_W +: SUM_W];
            if (cur_dir != DIR_W'(d)) begin
                if (cand > own_sum) begin
                    challenger_gt_own = 1'b1;
                end
                if (starve[d] && !found_starve) begin
                    found_starve = 1'b1;
                    starve_dir   = DIR_W'(d);
                end
                // Strict compare keeps the lowest index on ties.
                if (cand > best_sum) begin
                    found_best = 1'b1;
                    best_sum   = cand;
                    best_dir   = DIR_W'(d);
                end
            end
        end
        if (found_starve) begin
            next_dir = starve_dir;
        end else if (found_best) begin
            next_dir = best_dir;
        end else if (cur_dir == DIR_W'(N_DIR - 1)) begin
            next_dir = '0;
        end else begin
            next_dir = cur_dir + DIR_W'(1);
        end
    end

endmodule

// File: rtl/adaptive_phase_scheduler.sv
// Daytime traffic-phase scheduler: registers per-direction lane sums, then
// cycles GREEN -> YELLOW -> ALLRED granting one direction at a time, with
// min/max green timing and per-direction starvation protection.
module adaptive_phase_scheduler
    import traffic_pkg::*;
#(
    parameter int N_DIR      = 4,
    parameter int LANES      = 2,
    parameter int CNT_W      = 8,
    parameter int MIN_GREEN  = 8,
    parameter int MAX_GREEN  = 32,
    parameter int YELLOW_CYC = 3,
    parameter int ALLRED_CYC = 1,
    parameter int STARVE_LIM = 64
) (
    input logic                      clk,
    input logic                      rst,
    adaptive_phase_scheduler_if.slave bus
);

    localparam int SUM_W   = sum_w(CNT_W, LANES);
    localparam int DIR_W   = dir_w(N_DIR);
    localparam int LN      = N_DIR * LANES;
    localparam int TMR_A   = (MAX_GREEN > YELLOW_CYC) ? MAX_GREEN : YELLOW_CYC;
    localparam int TMR_MAX = (TMR_A > ALLRED_CYC) ? TMR_A : ALLRED_CYC;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam int STV_W   = $clog2(STARVE_LIM + 1);

    logic [SUM_W-1:0]       sum_p0 [N_DIR];
    logic [SUM_W-1:0]       sum_p1 [N_DIR];
    logic [N_DIR*SUM_W-1:0] sum_flat_p1;
    logic [STV_W-1:0]       stv_p2 [N_DIR];
    logic [N_DIR-1:0]       starve;
    logic                   starve_any;
    logic                   own_zero;

    phase_e                 phase_p2;
    logic [DIR_W-1:0]       cur_dir_p2;
    logic [TMR_W-1:0]       timer_p2;
    logic [LN-1:0]          green_p2;
    logic [LN-1:0]          yellow_p2;

    logic [DIR_W-1:0]       next_dir;
    logic                   challenger_gt_own;
    logic                   allred_done;
    logic                   enter_green;
    logic                   green_exit;

    function automatic logic [LN-1:0] lane_mask(input logic [DIR_W-1:0] d);
        logic [LN-1:0] m;
        m = '0;
        for (int l = 0; l < LANES; l++) begin
            m[int'(d)*LANES + l] = 1'b1;
        end
        return m;
    endfunction

    // Stage p0 -> p1: add up the lanes of every direction (zero-extended).
    always_comb begin
        for (int d = 0; d < N_DIR; d++) begin
            sum_p0[d] = '0;
            for (int l = 0; l < LANES; l++) begin
                sum_p0[d] = sum_p0[d] + SUM_W'(bus.lane_count[(d*LANES + l)*CNT_W +: CNT_W]);
            end
        end
    end

    // Register the sums; pure data, so no reset.
    always_ff @(posedge clk) begin
        sum_p1 <= sum_p0;
    end

    // Stage p1 -> p2: flatten sums, derive starvation flags and green-exit terms.
    always_comb begin
        starve_any = 1'b0;
        for (int d = 0; d < N_DIR; d++) begin
            sum_flat_p1[d*SUM_W +: SUM_W] = sum_p1[d];
            starve[d] = (stv_p2[d] >= STV_W'(STARVE_LIM));
            if (starve[d] && (cur_dir_p2 != DIR_W'(d))) begin
                starve_any = 1'b1;
            end
        end
        own_zero    = (sum_p1[cur_dir_p2] == '0);
        allred_done = (timer_p2 >= TMR_W'(ALLRED_CYC - 1));
        enter_green = (phase_p2 == PH_ALLRED) && allred_done && bus.enable;
        green_exit  = (timer_p2 >= TMR_W'(MIN_GREEN)) &&
                      (own_zero || challenger_gt_own || starve_any ||
                       (timer_p2 == TMR_W'(MAX_GREEN)));
    end

    dir_arbiter #(
        .N_DIR (N_DIR),
        .SUM_W (SUM_W),
        .DIR_W (DIR_W)
    ) u_dir_arbiter (
        .sums              (sum_flat_p1),
        .starve            (starve),
        .cur_dir           (cur_dir_p2),
        .next_dir          (next_dir),
        .challenger_gt_own (challenger_gt_own)
    );

    // Phase FSM with registered light outputs; enable low cuts green short.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_p2   <= PH_ALLRED;
            cur_dir_p2 <= '0;
            timer_p2   <= '0;
            green_p2   <= '0;
            yellow_p2  <= '0;
        end else begin
            case (phase_p2)
                PH_ALLRED: begin
                    if (allred_done) begin
                        if (bus.enable) begin
                            phase_p2   <= PH_GREEN;
                            cur_dir_p2 <= next_dir;
                            timer_p2   <= TMR_W'(1);
                            green_p2   <= lane_mask(next_dir);
                        end
                    end else begin
                        timer_p2 <= timer_p2 + TMR_W'(1);
                    end
                end
                PH_GREEN: begin
                    if (!bus.enable || green_exit) begin
                        phase_p2  <= PH_YELLOW;
                        timer_p2  <= TMR_W'(1);
                        green_p2  <= '0;
                        yellow_p2 <= lane_mask(cur_dir_p2);
                    end else begin
                        timer_p2 <= timer_p2 + TMR_W'(1);
                    end
                end
                PH_YELLOW: begin
                    if (timer_p2 >= TMR_W'(YELLOW_CYC)) begin
                        phase_p2  <= PH_ALLRED;
                        timer_p2  <= '0;
                        yellow_p2 <= '0;
                    end else begin
                        timer_p2 <= timer_p2 + TMR_W'(1);
                    end
                end
                default: begin
                    phase_p2  <= PH_ALLRED;
                    timer_p2  <= '0;
                    green_p2  <= '0;
                    yellow_p2 <= '0;
                end
            endcase
        end
    end

    // Starvation counters: count waiting cycles with traffic, saturate, clear on grant or empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int d = 0; d < N_DIR; d++) begin
                stv_p2[d] <= '0;
            end
        end else begin
            for (int d = 0; d < N_DIR; d++) begin
                if (enter_green && (next_dir == DIR_W'(d))) begin
                    stv_p2[d] <= '0;
                end else if (sum_p1[d] == '0) begin
                    stv_p2[d] <= '0;
                end else if ((phase_p2 == PH_GREEN) && (cur_dir_p2 == DIR_W'(d))) begin
                    stv_p2[d] <= stv_p2[d];
                end else if (stv_p2[d] < STV_W'(STARVE_LIM)) begin
                    stv_p2[d] <= stv_p2[d] + STV_W'(1);
                end
            end
        end
    end

    assign bus.green   = green_p2;
    assign bus.yellow  = yellow_p2;
    assign bus.cur_dir = cur_dir_p2;
    assign bus.phase   = phase_p2;

endmodule
